// File: rtl/horizontal_fir.sv
// Horizontal 5-tap symmetric FIR over a raster image stream.
// Row-edge clamping, pre-adder symmetric kernel, round + saturate.
module horizontal_fir #(
  parameter int         IMAGE_WIDTH  = 110,
  parameter int         IMAGE_HEIGHT = 103,
  parameter logic [7:0] COEF0        = 8'd1,
  parameter logic [7:0] COEF1        = 8'd4,
  parameter logic [7:0] COEF2        = 8'd6,
  parameter int         SHIFT        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pixel_in,
  input  logic       valid_in,
  output logic [7:0] pixel_out,
  output logic       valid_out,
  output logic       row_end,
  output logic       frame_done,
  output logic       busy
);

  localparam int            CW       = 10;
  localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMAGE_HEIGHT - 1);
  localparam logic [20:0]   ROUND    = (SHIFT > 0) ? 21'(1 << (SHIFT - 1)) : '0;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t        state, state_next;
  logic          flush_cnt, flush_next;
  logic          accept, advance, emit, last_in;
  logic [CW-1:0] in_col, in_row, out_col, out_row;

  logic [7:0]    taps [5];
  logic [7:0]    win  [5];

  logic          v0, re0, fd0;
  logic [CW-1:0] n0;
  logic          v1, re1, fd1;
  logic [8:0]    pre_outer, pre_inner;
  logic [7:0]    pre_centre;
  logic          v2, re2, fd2;
  logic [19:0]   mac;
  logic [20:0]   rounded, shifted;
  logic [7:0]    sat;

  // Position in the tap register of window element (centre n, offset d).
  // The newest tap always holds raster index n+2, so the clamped column j
  // sits at tap n+2-j, both inside a row and across the row boundary.
  function automatic logic [2:0] tap_pos(input logic [CW-1:0] n, input int d);
    int j;
    j = int'(n) + d;
    if (j < 0) j = 0;
    else if (j > IMAGE_WIDTH - 1) j = IMAGE_WIDTH - 1;
    return 3'(int'(n) + 2 - j);
  endfunction

  // Acceptance, tap advance and output-emission qualifiers.
  always_comb begin
    accept  = valid_in && (state != FLUSH);
    advance = accept || (state == FLUSH);
    last_in = (in_col == LAST_COL) && (in_row == LAST_ROW);
    emit    = (state == FLUSH) ||
              (accept && !((in_row == '0) && (in_col < CW'(2))));
  end

  // Next-state logic: FLUSH injects exactly two pseudo-samples.
  always_comb begin
    state_next = state;
    flush_next = 1'b0;
    case (state)
      IDLE:  if (accept) state_next = last_in ? FLUSH : RUN;
      RUN:   if (accept && last_in) state_next = FLUSH;
      FLUSH: begin
        flush_next = !flush_cnt;
        if (flush_cnt) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_next;
    end
  end

  // Input column/row counters, advanced by accepted samples only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_col <= '0;
      in_row <= '0;
    end else if (accept) begin
      if (in_col == LAST_COL) begin
        in_col <= '0;
        in_row <= (in_row == LAST_ROW) ? '0 : in_row + 1'b1;
      end else begin
        in_col <= in_col + 1'b1;
      end
    end
  end

  // Tap shift register; flush pseudo-samples repeat the newest tap and are
  // never selected because the window clamps to the last column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 5; i++) taps[i] <= '0;
    end else if (advance) begin
      taps[0] <= accept ? pixel_in : taps[0];
      for (int unsigned i = 1; i < 5; i++) taps[i] <= taps[i-1];
    end
  end

  // Output column/row counters and stage-0 tags for the emitted centre.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_col <= '0;
      out_row <= '0;
      v0      <= 1'b0;
      re0     <= 1'b0;
      fd0     <= 1'b0;
      n0      <= '0;
    end else begin
      v0 <= advance && emit;
      if (advance && emit) begin
        n0  <= out_col;
        re0 <= (out_col == LAST_COL);
        fd0 <= (out_col == LAST_COL) && (out_row == LAST_ROW);
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

  // Clamped window selection from the tap register.
  always_comb begin
    for (int unsigned k = 0; k < 5; k++) win[k] = taps[tap_pos(n0, int'(k) - 2)];
  end

  // Pre-add stage: symmetric pairs summed ahead of the multipliers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1         <= 1'b0;
      re1        <= 1'b0;
      fd1        <= 1'b0;
      pre_outer  <= '0;
      pre_inner  <= '0;
      pre_centre <= '0;
    end else begin
      v1         <= v0;
      re1        <= re0;
      fd1        <= fd0;
      pre_outer  <= {1'b0, win[0]} + {1'b0, win[4]};
      pre_inner  <= {1'b0, win[1]} + {1'b0, win[3]};
      pre_centre <= win[2];
    end
  end

  // Multiply-accumulate stage: three multipliers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2  <= 1'b0;
      re2 <= 1'b0;
      fd2 <= 1'b0;
      mac <= '0;
    end else begin
      v2  <= v1;
      re2 <= re1;
      fd2 <= fd1;
      mac <= 20'(COEF0) * 20'(pre_outer) + 20'(COEF1) * 20'(pre_inner) +
             20'(COEF2) * 20'(pre_centre);
    end
  end

  // Rounding, normalisation and saturation.
  always_comb begin
    rounded = {1'b0, mac} + ROUND;
    shifted = rounded >> SHIFT;
    sat     = (shifted > 21'd255) ? 8'hFF : shifted[7:0];
  end

  // Output register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_out  <= '0;
      valid_out  <= 1'b0;
      row_end    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= v2;
      row_end    <= v2 && re2;
      frame_done <= v2 && fd2;
      if (v2) pixel_out <= sat;
    end
  end

  // Busy from the first accepted sample until the cycle after frame_done,
  // unless a following frame has already started.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
    end else if (accept && (state == IDLE)) begin
      busy <= 1'b1;
    end else if (frame_done && (state == IDLE)) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_horizontal_fir.sv
// Directed self-checking bench for horizontal_fir at default image size.
module tb_horizontal_fir;

  localparam int W  = 110;
  localparam int H  = 103;
  localparam int N  = W * H;
  localparam int C0 = 1;
  localparam int C1 = 4;
  localparam int C2 = 6;
  localparam int SH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pixel_in = '0;
  logic       valid_in = 1'b0;
  logic [7:0] pixel_out;
  logic       valid_out, row_end, frame_done, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // capture state, owned by the capture process
  int   clr_gen = 0;
  int   seen_gen = 0;
  int   out_idx = 0, re_cnt = 0, re_bad = 0, fd_cnt = 0, fd_idx = -1, stray = 0;
  logic busy_at_fd = 1'b0, busy_after_fd = 1'b1;
  bit   fd_prev = 1'b0;
  logic [7:0] out_pix [N];
  int   out_edge [N];
  int   acc_edge [N];

  horizontal_fir #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .COEF0       (8'd1),
    .COEF1       (8'd4),
    .COEF2       (8'd6),
    .SHIFT       (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pixel_in  (pixel_in),
    .valid_in  (valid_in),
    .pixel_out (pixel_out),
    .valid_out (valid_out),
    .row_end   (row_end),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (seen_gen != clr_gen) begin
        seen_gen = clr_gen;
        out_idx = 0; re_cnt = 0; re_bad = 0; fd_cnt = 0; fd_idx = -1; stray = 0;
        busy_at_fd = 1'b0; busy_after_fd = 1'b1; fd_prev = 1'b0;
      end
      if (fd_prev) begin
        busy_after_fd = busy;
        fd_prev = 1'b0;
      end
      if (valid_out === 1'b1) begin
        if (out_idx < N) begin
          out_pix[out_idx]  = pixel_out;
          out_edge[out_idx] = cyc;
        end
        if (row_end === 1'b1) begin
          re_cnt++;
          if ((out_idx % W) != W - 1) re_bad++;
        end
        if (frame_done === 1'b1) begin
          fd_cnt++;
          fd_idx = out_idx;
          busy_at_fd = busy;
          fd_prev = 1'b1;
        end
        out_idx++;
      end else if (row_end !== 1'b0 || frame_done !== 1'b0) begin
        stray++;
      end
    end
  end

  function automatic logic [7:0] img(input int t, input int r, input int c);
    case (t)
      0: return 8'd100;
      1: return ((r == 5 && c == 50) || (r == 0 && c == 0) || (r == 0 && c == W - 1)) ? 8'd160 : 8'd0;
      2: return 8'd255;
      3: return 8'(c);
      default: return 8'd50;
    endcase
  endfunction

  // Direct 5-multiply reference with clamped column indices.
  function automatic int ref_pix(input int t, input int r, input int c);
    int k [5];
    int acc, cc;
    k = '{C0, C1, C2, C1, C0};
    acc = 0;
    for (int d = -2; d <= 2; d++) begin
      cc = c + d;
      if (cc < 0) cc = 0;
      if (cc > W - 1) cc = W - 1;
      acc += k[d + 2] * int'(img(t, r, cc));
    end
    acc = (acc + (1 << (SH - 1))) >> SH;
    return (acc > 255) ? 255 : acc;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] p);
    @(negedge clk);
    valid_in = v;
    pixel_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int t, input int first, input int count, input bit toggle);
    for (int i = first; i < first + count; i++) begin
      drive(1'b1, img(t, i / W, i % W));
      acc_edge[i] = cyc;
      if (toggle) drive(1'b0, 8'hA5);
    end
  endtask

  task automatic run_frame(input string name, input int t, input bit toggle, input bit poke);
    int mism, first_bad, exp_e, lat_bad, lat_first;
    clr_gen++;
    feed(t, 0, N, toggle);
    if (poke) begin
      drive(1'b1, 8'd200);
      drive(1'b1, 8'd200);
    end
    for (int i = 0; i < 40 && out_idx < N; i++) drive(1'b0, 8'd0);
    repeat (4) drive(1'b0, 8'd0);
    check($sformatf("%s.count", name), out_idx, N);
    check($sformatf("%s.row_end_count", name), re_cnt, H);
    check($sformatf("%s.row_end_column", name), re_bad, 0);
    check($sformatf("%s.frame_done_count", name), fd_cnt, 1);
    check($sformatf("%s.frame_done_index", name), fd_idx, N - 1);
    check($sformatf("%s.stray_flags", name), stray, 0);
    check($sformatf("%s.busy_at_frame_done", name), {31'd0, busy_at_fd}, 1);
    check($sformatf("%s.busy_after_frame_done", name), {31'd0, busy_after_fd}, 0);
    mism = 0;
    first_bad = -1;
    for (int i = 0; i < N && i < out_idx; i++) begin
      if (int'(out_pix[i]) != ref_pix(t, i / W, i % W)) begin
        if (first_bad < 0) first_bad = i;
        mism++;
      end
    end
    check($sformatf("%s.pixel_mismatches(first_at=%0d)", name, first_bad), mism, 0);
    if (toggle) begin
      lat_bad = 0;
      lat_first = -1;
      for (int k = 0; k < N && k < out_idx; k++) begin
        exp_e = (k < N - 2) ? acc_edge[k + 2] + 3 : acc_edge[N - 1] + 4 + (k - (N - 2));
        if (out_edge[k] != exp_e) begin
          if (lat_first < 0) lat_first = k;
          lat_bad++;
        end
      end
      check($sformatf("%s.latency_errors(first_at=%0d)", name, lat_first), lat_bad, 0);
    end
  endtask

  int ir [11] = '{5, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0};
  int ic [11] = '{48, 49, 50, 51, 52, 0, 1, 2, 109, 108, 107};
  int iv [11] = '{10, 40, 60, 40, 10, 110, 50, 10, 110, 50, 10};

  initial begin
    #12;
    check("reset.pixel_out", {24'd0, pixel_out}, 0);
    check("reset.valid_out", {31'd0, valid_out}, 0);
    check("reset.row_end", {31'd0, row_end}, 0);
    check("reset.frame_done", {31'd0, frame_done}, 0);
    check("reset.busy", {31'd0, busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_frame("const100", 0, 1'b0, 1'b1);

    run_frame("impulse", 1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++)
      check($sformatf("impulse.r%0d_c%0d", ir[i], ic[i]),
            {24'd0, out_pix[ir[i] * W + ic[i]]}, iv[i]);
    check("impulse.row1_col0", {24'd0, out_pix[W]}, 0);
    check("impulse.row1_col1", {24'd0, out_pix[W + 1]}, 0);
    check("impulse.row4_col50", {24'd0, out_pix[4 * W + 50]}, 0);

    run_frame("all255", 2, 1'b0, 1'b0);
    check("all255.sample", {24'd0, out_pix[N / 2]}, 255);

    run_frame("ramp_toggle", 3, 1'b1, 1'b0);
    check("ramp_toggle.interior", {24'd0, out_pix[7 * W + 60]}, 60);

    // partial frame, then asynchronous reset mid row 40
    clr_gen++;
    feed(4, 0, 40 * W + 30, 1'b0);
    valid_in = 1'b0;
    check("midframe.busy", {31'd0, busy}, 1);
    check("midframe.valid_out", {31'd0, valid_out}, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset.pixel_out", {24'd0, pixel_out}, 0);
    check("async_reset.valid_out", {31'd0, valid_out}, 0);
    check("async_reset.busy", {31'd0, busy}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("held_reset.valid_out", {31'd0, valid_out}, 0);
    check("held_reset.pixel_out", {24'd0, pixel_out}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clr_gen++;
    repeat (10) drive(1'b0, 8'd0);
    check("post_reset.residual_outputs", out_idx, 0);
    check("post_reset.busy", {31'd0, busy}, 0);
    run_frame("const50", 4, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
